// File: rtl/otp_pkg.sv
// otp_pkg: shared state encoding and default timing constants for the OTP session controller
package otp_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    SHOW    = 2'd2,
    LOCKOUT = 2'd3
  } otp_state_e;
  localparam int SHOW_TICKS_DEF   = 6;
  localparam int MAX_REQ_DEF      = 3;
  localparam int WINDOW_TICKS_DEF = 12;
  localparam int LOCK_TICKS_DEF   = 24;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector that ignores a level already high out of reset
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev;
  logic armed;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= armed | ~level;
    end
  end
  // armed stays low until the level has been seen low once after reset
  assign rise = level & ~prev & armed;
endmodule

// File: rtl/otp_session_ctrl.sv
// otp_session_ctrl: button-driven OTP display session with rate limiting and lockout
import otp_pkg::*;
module otp_session_ctrl #(
  parameter int SHOW_TICKS   = SHOW_TICKS_DEF,
  parameter int MAX_REQ      = MAX_REQ_DEF,
  parameter int WINDOW_TICKS = WINDOW_TICKS_DEF,
  parameter int LOCK_TICKS   = LOCK_TICKS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button_req,
  input  logic        tick_5s,
  input  logic [15:0] hash_in,
  input  logic        hash_update,
  output logic        disp_enable,
  output logic [15:0] disp_value,
  output logic        locked,
  output logic [1:0]  state_o
);
  localparam int SW = $clog2(SHOW_TICKS + 1);
  localparam int RW = $clog2(MAX_REQ + 1);
  localparam int WW = $clog2(WINDOW_TICKS + 1);
  localparam int LW = $clog2(LOCK_TICKS + 1);
  otp_state_e    state;
  logic          req;
  logic          arm_tick;
  logic          win_clr;
  logic [SW-1:0] show_cnt;
  logic [RW-1:0] req_cnt;
  logic [RW-1:0] req_eff;
  logic [WW-1:0] win_cnt;
  logic [LW-1:0] lock_cnt;
  rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .level (button_req),
    .rise  (req)
  );
  assign win_clr = tick_5s && state != LOCKOUT && win_cnt == WW'(WINDOW_TICKS - 1);
  // a request on the clearing tick sees the fresh window
  assign req_eff = win_clr ? '0 : req_cnt;
  assign state_o = state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      disp_enable <= 1'b0;
      disp_value  <= '0;
      locked      <= 1'b0;
      arm_tick    <= 1'b0;
      show_cnt    <= '0;
      req_cnt     <= '0;
      win_cnt     <= '0;
      lock_cnt    <= '0;
    end else begin
      if (tick_5s && state != LOCKOUT) win_cnt <= win_clr ? '0 : win_cnt + 1'b1;
      if (win_clr) req_cnt <= '0;
      case (state)
        IDLE: if (req) begin
          if (req_eff < RW'(MAX_REQ)) begin
            req_cnt  <= req_eff + 1'b1;
            arm_tick <= 1'b0;
            state    <= ARM;
          end else begin
            lock_cnt <= '0;
            locked   <= 1'b1;
            state    <= LOCKOUT;
          end
        end
        ARM: if (hash_update) begin
          disp_value  <= hash_in;
          show_cnt    <= SW'(SHOW_TICKS);
          disp_enable <= 1'b1;
          state       <= SHOW;
        end else if (tick_5s) begin
          arm_tick <= 1'b1;
          if (arm_tick) state <= IDLE;
        end
        SHOW: begin
          if (hash_update) disp_value <= hash_in;
          if (req) show_cnt <= SW'(SHOW_TICKS);
          else if (tick_5s) begin
            show_cnt <= show_cnt - 1'b1;
            if (show_cnt == SW'(1)) begin
              disp_enable <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        LOCKOUT: if (tick_5s) begin
          if (lock_cnt == LW'(LOCK_TICKS - 1)) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
            req_cnt  <= '0;
            win_cnt  <= '0;
            state    <= IDLE;
          end else lock_cnt <= lock_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_otp_session_ctrl.sv
// tb_otp_session_ctrl: directed scenarios checked every cycle against a session-level model
module tb_otp_session_ctrl;
  localparam int SHOWT = 6;
  localparam int MAXR  = 3;
  localparam int WINT  = 12;
  localparam int LOCKT = 24;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button_req = 1'b0;
  logic        tick_5s = 1'b0;
  logic [15:0] hash_in = '0;
  logic        hash_update = 1'b0;
  logic        disp_enable;
  logic [15:0] disp_value;
  logic        locked;
  logic [1:0]  state_o;
  int tests = 0;
  int fails = 0;
  otp_session_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .button_req  (button_req),
    .tick_5s     (tick_5s),
    .hash_in     (hash_in),
    .hash_update (hash_update),
    .disp_enable (disp_enable),
    .disp_value  (disp_value),
    .locked      (locked),
    .state_o     (state_o)
  );
  always #5 clk = ~clk;
  // mode: 0 idle, 1 waiting for code, 2 showing, 3 locked out
  typedef struct packed {
    int          mode;
    logic        prev;
    logic        seen_low;
    int          reqs;
    int          win;
    int          show_left;
    int          lock_ticks;
    int          arm_ticks;
    logic [15:0] val;
  } model_t;
  localparam model_t M0 = '0;
  model_t m = M0;
  function automatic model_t mstep(model_t c, logic b, logic t, logic hu, logic [15:0] hv);
    model_t n;
    logic press;
    n = c;
    press = b && !c.prev && c.seen_low;
    n.prev = b;
    n.seen_low = c.seen_low || !b;
    if (c.mode != 3 && t) begin
      n.win = c.win + 1;
      if (n.win == WINT) begin
        n.win = 0;
        n.reqs = 0;
      end
    end
    case (c.mode)
      0: if (press) begin
        if (n.reqs < MAXR) begin
          n.reqs = n.reqs + 1;
          n.arm_ticks = 0;
          n.mode = 1;
        end else begin
          n.lock_ticks = 0;
          n.mode = 3;
        end
      end
      1: if (hu) begin
        n.val = hv;
        n.show_left = SHOWT;
        n.mode = 2;
      end else if (t) begin
        n.arm_ticks = c.arm_ticks + 1;
        if (n.arm_ticks == 2) n.mode = 0;
      end
      2: begin
        if (hu) n.val = hv;
        if (press) n.show_left = SHOWT;
        else if (t) begin
          n.show_left = c.show_left - 1;
          if (n.show_left == 0) n.mode = 0;
        end
      end
      default: if (t) begin
        n.lock_ticks = c.lock_ticks + 1;
        if (n.lock_ticks == LOCKT) begin
          n.mode = 0;
          n.reqs = 0;
          n.win = 0;
        end
      end
    endcase
    return n;
  endfunction
  always @(posedge clk or posedge rst) m <= rst ? M0 : mstep(m, button_req, tick_5s, hash_update, hash_in);
  always @(negedge clk) begin
    tests++;
    if (disp_enable !== (m.mode == 2) || locked !== (m.mode == 3) ||
        state_o !== m.mode[1:0] || disp_value !== m.val) begin
      fails++;
      $display("FAIL model t=%0t en=%b lk=%b st=%0d val=%h expected en=%b lk=%b st=%0d val=%h",
               $time, disp_enable, locked, state_o, disp_value,
               m.mode == 2, m.mode == 3, m.mode[1:0], m.val);
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask
  task automatic cyc(input logic b, input logic t, input logic hu, input logic [15:0] v);
    button_req = b;
    tick_5s = t;
    hash_update = hu;
    hash_in = v;
    @(posedge clk);
    #1;
  endtask
  task automatic press();
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
  endtask
  initial begin
    do_reset();
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_outs", {disp_enable, locked, disp_value}, 32'h0);
    // basic session
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("press_arm", 32'(state_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'hBEEF);
    chk("show_beef", {15'h0, disp_enable, disp_value}, {15'h0, 1'b1, 16'hBEEF});
    ticks(5);
    chk("show_5ticks", 32'(disp_enable), 32'd1);
    ticks(1);
    chk("show_expire", {disp_enable, 1'b0, state_o}, 4'b0000);
    // rotating code and reload
    do_reset();
    press();
    cyc(1'b0, 1'b0, 1'b1, 16'hBEEF);
    cyc(1'b0, 1'b0, 1'b1, 16'h1234);
    chk("rotate_1234", 32'(disp_value), 32'h1234);
    ticks(3);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    ticks(5);
    chk("reload_still_on", 32'(disp_enable), 32'd1);
    ticks(1);
    chk("reload_expire", 32'(disp_enable), 32'd0);
    chk("value_held", 32'(disp_value), 32'h1234);
    // rate limit lockout
    do_reset();
    for (int k = 0; k < 3; k++) begin
      press();
      ticks(2);
    end
    chk("arm_timeout_idle", {disp_enable, 1'b0, state_o}, 4'b0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("lock_enter", {locked, 1'b0, state_o}, 4'b1011);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    press();
    cyc(1'b0, 1'b0, 1'b1, 16'h5555);
    chk("lock_ignores", {disp_enable, locked, disp_value}, {1'b0, 1'b1, 16'h0});
    ticks(23);
    chk("lock_23", 32'(locked), 32'd1);
    ticks(1);
    chk("lock_exit", {locked, 1'b0, state_o}, 4'b0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("post_lock_arm", 32'(state_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    // window clears after 12 ticks
    do_reset();
    for (int k = 0; k < 3; k++) begin
      press();
      ticks(2);
    end
    ticks(6);
    press();
    chk("win_clear_arm", 32'(state_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 16'hCAFE);
    chk("win_clear_show", {disp_enable, locked, disp_value}, {1'b1, 1'b0, 16'hCAFE});
    // request on the clearing tick
    do_reset();
    for (int k = 0; k < 3; k++) begin
      press();
      ticks(2);
    end
    ticks(5);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk("clear_same_cycle", 32'(state_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    // async reset mid-show with button held
    do_reset();
    press();
    cyc(1'b0, 1'b0, 1'b1, 16'hABCD);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {disp_enable, locked, 12'h0, state_o, disp_value}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("held_no_req", 32'(state_o), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("toggle_req", 32'(state_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/otp_session_ctrl.md
OTP_SESSION_CTRL -- requirements
Module: otp_session_ctrl

Interface
REQ-001 Parameter SHOW_TICKS, default 6, number of 5 s ticks a code stays displayed (30 s).
REQ-002 Parameter MAX_REQ, default 3, requests allowed per rate window before lockout.
REQ-003 Parameter WINDOW_TICKS, default 12, rate-window length in 5 s ticks (60 s).
REQ-004 Parameter LOCK_TICKS, default 24, lockout length in 5 s ticks (120 s).
REQ-005 Port clk, input, 1, 500 Hz clock; all logic rising-edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port button_req, input, 1, debounced button level, synchronous to clk.
REQ-008 Port tick_5s, input, 1, single-cycle pulse every 5 s, synchronous to clk.
REQ-009 Port hash_in, input, 16, current hasher output.
REQ-010 Port hash_update, input, 1, single-cycle pulse when hash_in has just refreshed.
REQ-011 Port disp_enable, output, 1, display enable for the BCD converter.
REQ-012 Port disp_value, output, 16, code to display.
REQ-013 Port locked, output, 1, high throughout LOCKOUT.
REQ-014 Port state_o, output, 2, encoded FSM state for debug.

Function
REQ-015 A request is a rising edge of button_req (registered previous value); level holds never re-trigger.
REQ-016 FSM states, encodings: IDLE=0, ARM=1, SHOW=2, LOCKOUT=3.
REQ-017 IDLE: on request with req_cnt < MAX_REQ -> req_cnt+1, go ARM; with req_cnt == MAX_REQ -> go LOCKOUT, lock_cnt=0.
REQ-018 ARM: on hash_update, latch hash_in into disp_value, load show_cnt=SHOW_TICKS, go SHOW; tick_5s in the same cycle is not applied to show_cnt.
REQ-019 ARM: if 2 tick_5s pulses arrive without hash_update, return to IDLE; the request stays counted.
REQ-020 SHOW: disp_enable=1; hash_update re-latches hash_in (rotating code), show_cnt unchanged.
REQ-021 SHOW: tick_5s decrements show_cnt; on the tick taking show_cnt from 1 to 0, go IDLE and drop disp_enable the next cycle.
REQ-022 SHOW: a request reloads show_cnt=SHOW_TICKS, does not increment req_cnt, and wins over a simultaneous tick_5s.
REQ-023 Rate window: outside LOCKOUT, win_cnt counts tick_5s; on reaching WINDOW_TICKS, win_cnt and req_cnt clear to 0 in the same cycle.
REQ-024 A request coinciding with a window clear in IDLE is evaluated against the cleared req_cnt (result req_cnt=1).
REQ-025 LOCKOUT: disp_enable=0, locked=1, requests ignored; lock_cnt counts tick_5s; at LOCK_TICKS go IDLE with req_cnt=0, win_cnt=0.
REQ-026 disp_enable=0 and disp_value holds its last value in every state except SHOW.
REQ-027 All outputs registered; latency from qualifying input event to output change is exactly one clk cycle.
REQ-028 Counter widths are sized with $clog2 of parameter+1; no counter wraps, each saturates or clears as specified.

Reset
REQ-029 rst asserted at any time forces IDLE, disp_enable=0, disp_value=16'h0000, locked=0, state_o=0, all counters 0, edge register 0.
REQ-030 A button_req held high through reset release does not produce a request.

Structure
REQ-031 Shared package otp_pkg holds the state enum typedef and the default parameter constants.
REQ-032 One sub-module, rise_detect, implements the registered rising-edge detector for button_req.

Verification
REQ-033 Reset, press, hash_update with hash_in=16'hBEEF -> disp_enable=1, disp_value=16'hBEEF next cycle; after 6 ticks disp_enable=0.
REQ-034 In SHOW, hash_update with hash_in=16'h1234 -> disp_value=16'h1234, show_cnt unchanged; press at tick 4 -> display lasts 6 further ticks.
REQ-035 Four presses within 12 ticks -> 4th press enters LOCKOUT, locked=1 for 24 ticks, presses ignored, then IDLE with req_cnt=0.
REQ-036 Press in ARM with no hash_update for 2 ticks -> IDLE, disp_enable stays 0, req_cnt=1.
REQ-037 Three presses, wait 12 ticks, press -> SHOW is entered (window cleared), no lockout.
REQ-038 rst asserted mid-SHOW with button held -> outputs to reset values immediately; no request after release until button toggles.
